// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared flag indices and FU result record for the core
package cpu_pkg;

    localparam int FLAG_BRANCH = 0;
    localparam int FLAG_WB     = 1;

    localparam int RES_ROBID_W = 4;
    localparam int RES_WBS_W   = 8;
    localparam int RES_FLAG_W  = 8;
    localparam int RES_DATA_W  = 8;

    typedef struct packed {
        logic [RES_ROBID_W-1:0] robid;
        logic [RES_WBS_W-1:0]   wbs;
        logic [RES_FLAG_W-1:0]  flags;
        logic [RES_DATA_W-1:0]  value;
    } fu_result_t;

endpackage

// File: rtl/rr_picker.sv
// rtl/rr_picker.sv - combinational round-robin picker, first request at or above ptr wins
module rr_picker #(
    parameter int N     = 8,
    parameter int PTR_W = $clog2(N)
) (
    input  logic [N-1:0]     req_i,
    input  logic [PTR_W-1:0] ptr_i,
    output logic [N-1:0]     grant_o,
    output logic [PTR_W-1:0] winner_o,
    output logic             valid_o
);

    always_comb begin
        int idx;
        grant_o  = '0;
        winner_o = '0;
        valid_o  = 1'b0;
        idx      = 0;
        for (int i = 0; i < N; i++) begin
            // Explicit modulo keeps the wrap correct when N is not a power of two.
            idx = (int'(ptr_i) + i) % N;
            if (!valid_o && req_i[idx[PTR_W-1:0]]) begin
                valid_o                   = 1'b1;
                grant_o[idx[PTR_W-1:0]]   = 1'b1;
                winner_o                  = idx[PTR_W-1:0];
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - round-robin arbiter feeding the registered CDB/ROB result slot
module cdb_arbiter
    import cpu_pkg::*;
#(
    parameter int FU_COUNT = 8,
    parameter int DATA_W   = 8,
    parameter int TAG_W    = 4,
    parameter int ROBID_W  = 4,
    parameter int FLAG_W   = 8
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [FU_COUNT-1:0]               fu_valid,
    input  logic [FU_COUNT-1:0][ROBID_W-1:0]  fu_robid,
    input  logic [FU_COUNT-1:0][7:0]          fu_wbs,
    input  logic [FU_COUNT-1:0][FLAG_W-1:0]   fu_flags,
    input  logic [FU_COUNT-1:0][DATA_W-1:0]   fu_value,
    output logic [FU_COUNT-1:0]               fu_ready,
    input  logic                              rob_ready,
    input  logic                              flush,
    output logic                              rob_transmit,
    output logic [ROBID_W-1:0]                rob_id,
    output logic [FLAG_W-1:0]                 rob_flags,
    output logic [7:0]                        rob_wbs,
    output logic [DATA_W-1:0]                 rob_value,
    output logic                              cdb_transmit,
    output logic [TAG_W-1:0]                  cdb_id,
    output logic [DATA_W-1:0]                 cdb_val
);

    localparam int PTR_W = $clog2(FU_COUNT);

    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic               tx_q, tx_d;
    logic [ROBID_W-1:0] robid_q, robid_d;
    logic [FLAG_W-1:0]  flags_q, flags_d;
    logic [7:0]         wbs_q, wbs_d;
    logic [DATA_W-1:0]  value_q, value_d;

    logic                slot_free;
    logic                grant_en;
    logic [FU_COUNT-1:0] grant;
    logic [PTR_W-1:0]    winner;
    logic                any_grant;

    // Reset gates the grant so fu_ready is low while rst is asserted.
    assign slot_free = !tx_q || rob_ready;
    assign grant_en  = rst && slot_free && !flush;

    rr_picker #(
        .N     (FU_COUNT),
        .PTR_W (PTR_W)
    ) u_picker (
        .req_i    (fu_valid & {FU_COUNT{grant_en}}),
        .ptr_i    (ptr_q),
        .grant_o  (grant),
        .winner_o (winner),
        .valid_o  (any_grant)
    );

    assign fu_ready = grant;

    always_comb begin
        ptr_d   = ptr_q;
        tx_d    = tx_q;
        robid_d = robid_q;
        flags_d = flags_q;
        wbs_d   = wbs_q;
        value_d = value_q;
        // An empty slot carries all-zero fields so downstream OR-merging stays safe.
        if (flush || (slot_free && !any_grant)) begin
            tx_d    = 1'b0;
            robid_d = '0;
            flags_d = '0;
            wbs_d   = '0;
            value_d = '0;
        end else if (any_grant) begin
            tx_d    = 1'b1;
            robid_d = fu_robid[winner];
            flags_d = fu_flags[winner];
            wbs_d   = fu_wbs[winner];
            value_d = fu_value[winner];
            if (winner == PTR_W'(FU_COUNT - 1)) begin
                ptr_d = '0;
            end else begin
                ptr_d = winner + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q   <= '0;
            tx_q    <= 1'b0;
            robid_q <= '0;
            flags_q <= '0;
            wbs_q   <= '0;
            value_q <= '0;
        end else begin
            ptr_q   <= ptr_d;
            tx_q    <= tx_d;
            robid_q <= robid_d;
            flags_q <= flags_d;
            wbs_q   <= wbs_d;
            value_q <= value_d;
        end
    end

    assign rob_transmit = tx_q;
    assign rob_id       = robid_q;
    assign rob_flags    = flags_q;
    assign rob_wbs      = wbs_q;
    assign rob_value    = value_q;
    assign cdb_transmit = tx_q && flags_q[FLAG_WB];
    assign cdb_id       = wbs_q[TAG_W-1:0];
    assign cdb_val      = value_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb/tb_cdb_arbiter.sv - randomized and directed bench for cdb_arbiter against a behavioural model
module tb_cdb_arbiter;
    import cpu_pkg::*;

    localparam int NFU = 8;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NFU-1:0]       fu_valid;
    logic [NFU-1:0][3:0]  fu_robid;
    logic [NFU-1:0][7:0]  fu_wbs;
    logic [NFU-1:0][7:0]  fu_flags;
    logic [NFU-1:0][7:0]  fu_value;
    logic [NFU-1:0]       fu_ready;
    logic                 rob_ready;
    logic                 flush;
    logic                 rob_transmit;
    logic [3:0]           rob_id;
    logic [7:0]           rob_flags;
    logic [7:0]           rob_wbs;
    logic [7:0]           rob_value;
    logic                 cdb_transmit;
    logic [3:0]           cdb_id;
    logic [7:0]           cdb_val;

    cdb_arbiter #(
        .FU_COUNT (NFU), .DATA_W (8), .TAG_W (4), .ROBID_W (4), .FLAG_W (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .fu_valid     (fu_valid),
        .fu_robid     (fu_robid),
        .fu_wbs       (fu_wbs),
        .fu_flags     (fu_flags),
        .fu_value     (fu_value),
        .fu_ready     (fu_ready),
        .rob_ready    (rob_ready),
        .flush        (flush),
        .rob_transmit (rob_transmit),
        .rob_id       (rob_id),
        .rob_flags    (rob_flags),
        .rob_wbs      (rob_wbs),
        .rob_value    (rob_value),
        .cdb_transmit (cdb_transmit),
        .cdb_id       (cdb_id),
        .cdb_val      (cdb_val)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // FU-side pending results and the behavioural picture of the result bus.
    bit         fv [NFU];
    fu_result_t fr [NFU];
    bit         refill;
    bit         m_v;
    fu_result_t m_r;
    int         m_ptr;
    int         last_w;
    int         glog [$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic fu_result_t rand_res();
        logic [31:0] t;
        t = $urandom;
        return t[27:0];
    endfunction

    function automatic logic [63:0] bus_obs();
        return {22'b0, rob_transmit, rob_id, rob_flags, rob_wbs, rob_value,
                cdb_transmit, cdb_id, cdb_val};
    endfunction

    function automatic logic [63:0] bus_exp();
        if (!m_v) return 64'b0;
        return {22'b0, 1'b1, m_r.robid, m_r.flags, m_r.wbs, m_r.value,
                m_r.flags[FLAG_WB], m_r.wbs[3:0], m_r.value};
    endfunction

    task automatic drive();
        for (int i = 0; i < NFU; i++) begin
            fu_valid[i] = fv[i];
            fu_robid[i] = fr[i].robid;
            fu_wbs[i]   = fr[i].wbs;
            fu_flags[i] = fr[i].flags;
            fu_value[i] = fr[i].value;
        end
    endtask

    // One bus cycle: called at a negedge with flush/rob_ready already set.
    task automatic step();
        int w;
        bit free;
        drive();
        #1;
        free = !m_v || rob_ready;
        w = -1;
        if (!flush && free) begin
            for (int k = 0; k < NFU; k++) begin
                int j;
                j = (m_ptr + k) % NFU;
                if (w < 0 && fv[j]) w = j;
            end
        end
        chk("fu_ready", 64'(fu_ready), (w < 0) ? 64'd0 : (64'd1 << w));
        @(posedge clk);
        if (flush) m_v = 1'b0;
        else if (w >= 0) begin
            m_v = 1'b1;
            m_r = fr[w];
            m_ptr = (w + 1) % NFU;
        end else if (free) m_v = 1'b0;
        last_w = w;
        if (w >= 0) begin
            glog.push_back(w);
            if (refill) fr[w] = rand_res();
            else fv[w] = 1'b0;
        end
        @(negedge clk);
        chk("bus", bus_obs(), bus_exp());
    endtask

    task automatic clear_fus();
        for (int i = 0; i < NFU; i++) begin
            fv[i] = 1'b0;
            fr[i] = rand_res();
        end
    endtask

    task automatic do_reset();
        clear_fus();
        drive();
        rst = 1'b0;
        #1;
        chk("rst_bus", bus_obs(), 64'd0);
        chk("rst_ready", 64'(fu_ready), 64'd0);
        m_v = 1'b0;
        m_ptr = 0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        int cnt [NFU];
        rst = 1'b0; rob_ready = 1'b1; flush = 1'b0; refill = 1'b0;
        m_v = 1'b0; m_ptr = 0; last_w = -1;
        clear_fus();
        drive();
        @(negedge clk);
        @(negedge clk);
        chk("reset_bus", bus_obs(), 64'd0);
        chk("reset_ready", 64'(fu_ready), 64'd0);
        rst = 1'b1;

        // Reset during a stall discards the slot and returns the pointer to 0.
        fv[2] = 1'b1;
        step();
        rob_ready = 1'b0;
        repeat (3) step();
        fv[5] = 1'b1;
        drive();
        #2 rst = 1'b0;
        #1;
        chk("midrst_bus", bus_obs(), 64'd0);
        chk("midrst_ready", 64'(fu_ready), 64'd0);
        clear_fus();
        drive();
        m_v = 1'b0; m_ptr = 0;
        @(negedge clk);
        rst = 1'b1; rob_ready = 1'b1;
        #1;
        chk("post_rst_ready", 64'(fu_ready), 64'd0);

        // Collision from ptr 0: FU0 then FU2.
        glog.delete();
        fv[0] = 1'b1; fv[2] = 1'b1;
        repeat (3) step();
        chk("coll_first", 64'(glog[0]), 64'd0);
        chk("coll_second", 64'(glog[1]), 64'd2);

        // Single request, then pointer 3 must still pick FU2 after wrapping.
        fv[2] = 1'b1;
        fr[2].robid = 4'd5; fr[2].value = 8'hA7; fr[2].flags = 8'h02; fr[2].wbs = 8'h9C;
        step();
        chk("single_grant", 64'(last_w), 64'd2);
        chk("single_bus", {rob_transmit, rob_id, cdb_transmit, cdb_id, cdb_val},
            {1'b1, 4'd5, 1'b1, 4'hC, 8'hA7});
        step();

        // Fairness with every FU continuously valid.
        do_reset();
        refill = 1'b1;
        for (int i = 0; i < NFU; i++) fv[i] = 1'b1;
        glog.delete();
        repeat (16) step();
        for (int i = 0; i < NFU; i++) cnt[i] = 0;
        for (int k = 0; k < 16; k++) begin
            chk("fair_order", 64'(glog[k]), 64'(k % NFU));
            cnt[glog[k]]++;
        end
        for (int i = 0; i < NFU; i++) chk("fair_count", 64'(cnt[i]), 64'd2);

        // Backpressure with results pending, then drain and reload together.
        rob_ready = 1'b0;
        repeat (4) step();
        rob_ready = 1'b1;
        step();
        refill = 1'b0;

        // Flush with a full slot and FU1 waiting.
        clear_fus();
        fv[1] = 1'b1; fv[6] = 1'b1;
        rob_ready = 1'b0;
        step();
        flush = 1'b1;
        step();
        chk("flush_tx", 64'(rob_transmit), 64'd0);
        flush = 1'b0; rob_ready = 1'b1;
        repeat (3) step();

        // Branch-only result reaches the ROB but not the CDB.
        fv[4] = 1'b1;
        fr[4].flags = 8'h01;
        step();
        chk("flag_rob_tx", 64'(rob_transmit), 64'd1);
        chk("flag_cdb_tx", 64'(cdb_transmit), 64'd0);
        step();

        // Randomized traffic with stalls, flushes and squashes.
        refill = 1'b0;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NFU; i++)
                if (!fv[i] && ($urandom % 3 == 0)) begin
                    fv[i] = 1'b1;
                    fr[i] = rand_res();
                end
            rob_ready = ($urandom % 4) != 0;
            flush = ($urandom % 20) == 0;
            step();
            if (flush)
                for (int i = 0; i < NFU; i++)
                    if ($urandom % 2 == 0) fv[i] = 1'b0;
        end
        flush = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Round-robin arbiter that shares the single registered result bus (CDB broadcast plus ROB write) between the functional units.
- Replaces the OR-reduce / daisy-chained transmit merge with an explicit valid/ready handshake, so simultaneous FU completions are serialised instead of corrupting the bus.
- Sits between the FU outputs and the ROB / issuer CDB inputs; exactly one result per cycle is driven onto the bus.

Parameters:
- FU_COUNT, 8, number of requesting FUs (2..16).
- DATA_W, 8, result value width.
- TAG_W, 4, physical register tag width.
- ROBID_W, 4, ROB entry id width.
- FLAG_W, 8, flags width.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- fu_valid  in  FU_COUNT  per-FU result pending.
- fu_robid  in  FU_COUNT x ROBID_W  per-FU ROB id.
- fu_wbs  in  FU_COUNT x 8  per-FU writeback tags: [3:0] new tag, [7:4] old tag.
- fu_flags  in  FU_COUNT x FLAG_W  per-FU flags.
- fu_value  in  FU_COUNT x DATA_W  per-FU result.
- fu_ready  out  FU_COUNT  one-hot grant; the result is consumed in any cycle where valid and ready are both high.
- rob_ready  in  1  ROB can accept a result this cycle.
- flush  in  1  branch squash.
- rob_transmit  out  1  bus holds a valid ROB result.
- rob_id  out  ROBID_W  ROB id of the result.
- rob_flags  out  FLAG_W  flags of the result.
- rob_wbs  out  8  writeback tags of the result.
- rob_value  out  DATA_W  result value.
- cdb_transmit  out  1  broadcast on CDB.
- cdb_id  out  TAG_W  broadcast tag.
- cdb_val  out  DATA_W  broadcast value.

Behaviour:
- Reset (rst low, asynchronous):
  - All outputs drive 0 and fu_ready is 0.
  - ptr (round-robin pointer, clog2(FU_COUNT) bits) resets to 0.
  - Any in-flight result is discarded.
- Output slot: one register stage.
  - Slot "free" = !rob_transmit | rob_ready; the slot is draining this cycle.
- Arbitration (combinational, each cycle):
  - If the slot is free and flush is low, scan fu_valid starting at index ptr upward, wrapping modulo FU_COUNT.
  - The first set bit wins and gets fu_ready[winner] = 1; all other fu_ready bits are 0.
  - No valid requester gives all fu_ready bits 0.
- Grant edge:
  - Slot loads the winner's fields.
  - rob_transmit <= 1.
  - ptr <= (winner+1) mod FU_COUNT.
  - Latency is exactly 1 cycle from handshake to bus.
- Drain without a new grant: rob_transmit <= 0 and ptr is held.
- Backpressure:
  - If rob_transmit=1 and rob_ready=0, the slot holds every output stable and fu_ready stays 0.
  - cdb_transmit is held high for the whole stall; consumers ignore repeat broadcasts.
- CDB fields:
  - cdb_transmit = rob_transmit & rob_flags[FLAG_WB].
  - cdb_id = rob_wbs[3:0].
  - cdb_val = rob_value.
- FU rules:
  - An FU keeps valid and data stable until its handshake.
  - A grant is never revoked within its cycle.
- flush high:
  - No grant that cycle.
  - Slot cleared next edge: rob_transmit <= 0, overriding any stall.
  - ptr is held.
  - FUs own the squashing of their own pending results.
- Simultaneous events:
  - Drain and new grant in the same cycle are legal (back-to-back, one result per cycle).
  - flush with a concurrent drain clears the slot.
- Fairness: with all FUs continuously valid, every FU is granted once per FU_COUNT cycles. Starvation is bounded by FU_COUNT grants.
- Width rules:
  - ptr wraps with an explicit mod for non-power-of-2 FU_COUNT.
  - Bus fields are zero when rob_transmit=0, so downstream OR-merging stays safe.

Decomposition:
- Package cpu_pkg holds:
  - FLAG_WB: bit index 1 of flags, marking register-writing results.
  - FLAG_BRANCH: bit index 0.
  - Typedef fu_result_t: robid, wbs, flags, value.
- Sub-module rr_picker (combinational): inputs req and ptr; outputs one-hot grant and encoded winner. It is reusable by the issuer for RS selection.

Test Plan:
- Reset mid-stall: FU2 granted with rob_ready=0 for 3 cycles, then drop rst -> all outputs are 0 immediately, and after release ptr=0 and fu_ready=0.
- Single request: fu_valid=8'h04, robid=5, value=8'hA7, flags=8'h02 with rob_ready=1 -> fu_ready=8'h04 in that cycle; the next cycle has rob_transmit=1, rob_id=5, cdb_transmit=1, cdb_id=wbs[3:0], cdb_val=8'hA7.
- Collision: fu_valid=8'h05 held with ptr=0 -> FU0 granted first, then FU2 the next cycle. Bus shows FU0 then FU2 on consecutive cycles and ptr ends at 3.
- Fairness: all 8 FUs valid for 16 cycles with rob_ready=1 -> each FU is granted exactly twice, in order 0..7,0..7.
- Backpressure: rob_ready=0 for 4 cycles with results pending -> fu_ready=0 and bus fields unchanged. When rob_ready rises, the next winner is loaded in the same cycle as the drain.
- Flush: flush=1 while the slot is full and FU1 is valid -> fu_ready=0, the next cycle has rob_transmit=0, and ptr is unchanged.
- Flag gating: granted result with flags=8'h01 (branch, no writeback) -> rob_transmit=1, cdb_transmit=0.
